// File: rtl/ifetch_unit_if.sv
// Instruction-memory request/acknowledge port between the fetch stage and imem.
interface ifetch_unit_if;
  logic        imem_req;
  logic [31:0] imem_addr;
  logic        imem_ack;
  logic [31:0] imem_rdata;

  modport master (
    output imem_req,
    output imem_addr,
    input  imem_ack,
    input  imem_rdata
  );

  modport slave (
    input  imem_req,
    input  imem_addr,
    output imem_ack,
    output imem_rdata
  );
endinterface

// File: rtl/ifetch_unit.sv
// Instruction fetch and PC sequencing for the single-cycle MIPS core.
// Fetches one word per instruction over a req/ack port, holds it for
// decode/execute, and steps the PC according to the decoder's NPCOP.
module ifetch_unit #(
  parameter logic [31:0] RESET_PC = 32'h0000_3000
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic [1:0]           npcop,
  input  logic [31:0]          rs_data,
  input  logic                 hold,
  ifetch_unit_if.master        imem,
  output logic [31:0]          instr,
  output logic [5:0]           opcode,
  output logic [5:0]           funct,
  output logic                 instr_valid,
  output logic [31:0]          pc,
  output logic [31:0]          pc_plus4,
  output logic                 fault
);

  localparam logic [1:0] ST_RST   = 2'd0;
  localparam logic [1:0] ST_FETCH = 2'd1;
  localparam logic [1:0] ST_EXEC  = 2'd2;
  localparam logic [1:0] ST_FAULT = 2'd3;

  localparam logic [1:0] NPC_SEQ    = 2'b00;
  localparam logic [1:0] NPC_BRANCH = 2'b01;
  localparam logic [1:0] NPC_JUMP   = 2'b10;
  localparam logic [1:0] NPC_JR     = 2'b11;

  logic [1:0]  state;
  logic [31:0] npc;
  logic [31:0] branch_off;

  // Decoder-facing slices and the link value are pure functions of state regs.
  always_comb begin
    opcode         = instr[31:26];
    funct          = instr[5:0];
    pc_plus4       = pc + 32'd4;
    instr_valid    = (state == ST_EXEC);
    imem.imem_req  = (state == ST_FETCH);
    imem.imem_addr = pc;
  end

  // Next-PC select from the decoder's NPCOP.
  always_comb begin
    branch_off = {{14{instr[15]}}, instr[15:0], 2'b00};
    npc        = pc_plus4;
    unique case (npcop)
      NPC_SEQ:    npc = pc_plus4;
      NPC_BRANCH: npc = pc_plus4 + branch_off;
      NPC_JUMP:   npc = {pc_plus4[31:28], instr[25:0], 2'b00};
      NPC_JR:     npc = rs_data;
      default:    npc = pc_plus4;
    endcase
  end

  // Fetch/execute sequencer; reset wins from any state and drops any pending fetch.
  always_ff @(posedge clk) begin
    if (rst) begin
      state <= ST_RST;
      pc    <= RESET_PC;
      instr <= '0;
      fault <= 1'b0;
    end else begin
      unique case (state)
        ST_RST: state <= ST_FETCH;
        ST_FETCH: begin
          if (imem.imem_ack) begin
            instr <= imem.imem_rdata;
            state <= ST_EXEC;
          end
        end
        ST_EXEC: begin
          if (!hold) begin
            // Faulting target is still committed so it is visible on pc.
            pc <= npc;
            if (npc[1:0] != 2'b00) begin
              fault <= 1'b1;
              state <= ST_FAULT;
            end else begin
              state <= ST_FETCH;
            end
          end
        end
        ST_FAULT: state <= ST_FAULT;
        default:  state <= ST_RST;
      endcase
    end
  end

endmodule

// File: tb/tb_ifetch_unit.sv
// Directed self-checking bench for ifetch_unit.
module tb_ifetch_unit;
  logic        clk = 1'b0;
  logic        rst;
  logic [1:0]  npcop;
  logic [31:0] rs_data;
  logic        hold;
  logic [31:0] instr;
  logic [5:0]  opcode;
  logic [5:0]  funct;
  logic        instr_valid;
  logic [31:0] pc;
  logic [31:0] pc_plus4;
  logic        fault;

  int unsigned tests  = 0;
  int unsigned failed = 0;

  ifetch_unit_if imem_bus ();

  ifetch_unit #(.RESET_PC(32'h0000_3000)) dut (
    .clk        (clk),
    .rst        (rst),
    .npcop      (npcop),
    .rs_data    (rs_data),
    .hold       (hold),
    .imem       (imem_bus),
    .instr      (instr),
    .opcode     (opcode),
    .funct      (funct),
    .instr_valid(instr_valid),
    .pc         (pc),
    .pc_plus4   (pc_plus4),
    .fault      (fault)
  );

  always #5 clk = ~clk;

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    tests++;
    assert (obs === exp) else begin
      failed++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  // From FETCH: deliver one word with zero wait states, landing in EXEC.
  task automatic fetch(input logic [31:0] word);
    imem_bus.imem_ack   = 1'b1;
    imem_bus.imem_rdata = word;
    step();
    imem_bus.imem_ack   = 1'b0;
  endtask

  // From EXEC: release with the given NPCOP.
  task automatic exec(input logic [1:0] op, input logic [31:0] rs);
    npcop   = op;
    rs_data = rs;
    hold    = 1'b0;
    step();
    npcop   = 2'b00;
  endtask

  initial begin
    #50000;
    $display("FAIL watchdog: observed timeout expected finish");
    $fatal(1, "timeout");
  end

  initial begin
    rst = 1'b1; npcop = 2'b00; rs_data = '0; hold = 1'b0;
    imem_bus.imem_ack = 1'b0; imem_bus.imem_rdata = '0;
    step(); step();
    check("rst_req",   imem_bus.imem_req, 1'b0);
    check("rst_valid", instr_valid, 1'b0);
    check("rst_pc",    pc, 32'h0000_3000);
    check("rst_instr", instr, 32'h0);
    check("rst_fault", fault, 1'b0);

    rst = 1'b0;
    step();
    check("first_req",  imem_bus.imem_req, 1'b1);
    check("first_addr", imem_bus.imem_addr, 32'h0000_3000);

    // Sequential flow
    fetch(32'h0000_0000);
    check("seq_valid_exec", instr_valid, 1'b1);
    check("seq_req_exec", imem_bus.imem_req, 1'b0);
    exec(2'b00, '0);
    check("seq_addr1", imem_bus.imem_addr, 32'h0000_3004);
    check("seq_valid_fetch", instr_valid, 1'b0);
    fetch(32'h0000_0000); exec(2'b00, '0);
    check("seq_addr2", imem_bus.imem_addr, 32'h0000_3008);
    fetch(32'h0000_0000); exec(2'b00, '0);
    fetch(32'h0000_0000); exec(2'b00, '0);
    check("seq_addr4", imem_bus.imem_addr, 32'h0000_3010);

    // Backward branch: 0x3014 - 8
    fetch(32'h1000_FFFE);
    check("beq_opcode", opcode, 6'h04);
    exec(2'b01, '0);
    check("br_back", imem_bus.imem_addr, 32'h0000_300C);
    fetch(32'h0000_0000); exec(2'b00, '0);
    // Forward branch: 0x3014 + 12
    fetch(32'h1000_0003); exec(2'b01, '0);
    check("br_fwd", imem_bus.imem_addr, 32'h0000_3020);

    // jal
    fetch(32'h0C00_0C40);
    check("jal_opcode", opcode, 6'h03);
    check("jal_funct", funct, 6'h00);
    exec(2'b10, '0);
    check("jal_addr", imem_bus.imem_addr, 32'h0000_3100);

    // jr
    fetch(32'h0000_0008);
    check("jr_link", pc_plus4, 32'h0000_3104);
    check("jr_funct", funct, 6'h08);
    exec(2'b11, 32'h0000_4000);
    check("jr_addr", imem_bus.imem_addr, 32'h0000_4000);

    // Wait states
    for (int i = 0; i < 3; i++) begin
      step();
      check("wait_req", imem_bus.imem_req, 1'b1);
      check("wait_addr", imem_bus.imem_addr, 32'h0000_4000);
      check("wait_instr", instr, 32'h0000_0008);
    end
    fetch(32'h2408_0001);
    check("wait_done_instr", instr, 32'h2408_0001);

    // Hold with spurious ack
    hold = 1'b1;
    imem_bus.imem_ack = 1'b1; imem_bus.imem_rdata = 32'hDEAD_BEEF;
    npcop = 2'b11; rs_data = 32'h0000_0002;
    for (int i = 0; i < 2; i++) begin
      step();
      check("hold_valid", instr_valid, 1'b1);
      check("hold_pc", pc, 32'h0000_4000);
      check("hold_instr", instr, 32'h2408_0001);
      check("hold_fault", fault, 1'b0);
    end
    imem_bus.imem_ack = 1'b0;
    exec(2'b00, '0);
    check("hold_release", imem_bus.imem_addr, 32'h0000_4004);

    // Misaligned jr
    fetch(32'h0000_0009);
    exec(2'b11, 32'h0000_4002);
    check("mis_fault", fault, 1'b1);
    check("mis_pc", pc, 32'h0000_4002);
    check("mis_valid", instr_valid, 1'b0);
    imem_bus.imem_ack = 1'b1;
    for (int i = 0; i < 3; i++) begin
      step();
      check("mis_req", imem_bus.imem_req, 1'b0);
      check("mis_sticky", fault, 1'b1);
    end
    imem_bus.imem_ack = 1'b0;
    rst = 1'b1;
    step();
    check("clr_pc", pc, 32'h0000_3000);
    check("clr_fault", fault, 1'b0);
    rst = 1'b0;
    step();
    check("clr_refetch", imem_bus.imem_addr, 32'h0000_3000);
    check("clr_req", imem_bus.imem_req, 1'b1);

    // Reset mid-fetch, late ack ignored
    fetch(32'h0000_0000); exec(2'b00, '0);
    step();
    check("mid_wait_addr", imem_bus.imem_addr, 32'h0000_3004);
    rst = 1'b1;
    step();
    rst = 1'b0;
    imem_bus.imem_ack = 1'b1; imem_bus.imem_rdata = 32'hAAAA_AAAA;
    step();
    imem_bus.imem_ack = 1'b0;
    check("mid_instr", instr, 32'h0);
    check("mid_valid", instr_valid, 1'b0);
    check("mid_addr", imem_bus.imem_addr, 32'h0000_3000);

    // PC wrap
    fetch(32'h0000_0008); exec(2'b11, 32'hFFFF_FFFC);
    check("wrap_pre", imem_bus.imem_addr, 32'hFFFF_FFFC);
    fetch(32'h0000_0000);
    check("wrap_link", pc_plus4, 32'h0000_0000);
    exec(2'b00, '0);
    check("wrap_addr", imem_bus.imem_addr, 32'h0000_0000);
    check("wrap_fault", fault, 1'b0);

    $display("[TB] %0d tests run, %0d failed", tests, failed);
    $finish;
  end
endmodule
